// File: rtl/ahb_req_arbiter_pkg.sv
// rtl/ahb_req_arbiter_pkg.sv - shared state encoding, defaults and width helper for the AHB request arbiter
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// rtl/ahb_req_arbiter_if.sv - requester and ahb_master side signals of the arbiter
interface ahb_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [31:0]        rdata;
    logic               m_enable;
    logic [31:0]        m_addr;
    logic               m_wr;
    logic [31:0]        m_dina;
    logic [1:0]         m_slave_sel;
    logic               m_hready;
    logic [31:0]        m_dout;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, m_hready, m_dout,
        output gnt, done, err, rdata, m_enable, m_addr, m_wr, m_dina, m_slave_sel
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, m_hready, m_dout,
        input  gnt, done, err, rdata, m_enable, m_addr, m_wr, m_dina, m_slave_sel
    );
endinterface

// File: rtl/ahb_req_arbiter_rr_pick.sv
// rtl/ahb_req_arbiter_rr_pick.sv - round-robin winner select starting at ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);
    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_off;

    // Rotate so that bit 0 is the requester at ptr, then lowest set bit wins.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = i_req[(int'(i_ptr) + i) % NREQ];
        end
    end

    always_comb begin
        w_off   = '0;
        o_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off   = IW'(i);
                o_valid = 1'b1;
            end
        end
    end

    assign o_idx = IW'((int'(i_ptr) + int'(w_off)) % NREQ);

endmodule

// File: rtl/ahb_req_arbiter.sv
// rtl/ahb_req_arbiter.sv - shares one ahb_master between NREQ requesters, round-robin, with timeout abort
module ahb_req_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             hclk,
    input  logic             hresetn,
    ahb_req_arbiter_if.slave io_bus
);
    localparam int IW = clog2(NREQ);
    localparam int TW = clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_hcnt;
    logic [TW-1:0]   r_tcnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic            r_enable;
    logic [31:0]     r_addr;
    logic            r_wr;
    logic [31:0]     r_dina;

    logic            w_valid;
    logic [IW-1:0]   w_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req   (io_bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_hcnt   <= '0;
            r_tcnt   <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_enable <= 1'b0;
            r_addr   <= '0;
            r_wr     <= 1'b0;
            r_dina   <= '0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state  <= S_ISSUE;
                        r_idx    <= w_idx;
                        r_gnt    <= NREQ'(1) << w_idx;
                        r_addr   <= io_bus.req_addr[32*w_idx +: 32];
                        r_wr     <= io_bus.req_wr[w_idx];
                        r_dina   <= io_bus.req_wdata[32*w_idx +: 32];
                        r_enable <= 1'b1;
                        r_ptr    <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                    end
                end
                S_ISSUE: begin
                    r_hcnt  <= '0;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (io_bus.m_hready) r_hcnt <= r_hcnt + 2'd1;
                    // First hready-high is the data phase; the second carries the latched hrdata.
                    if (io_bus.m_hready && r_hcnt == 2'd1) begin
                        r_rdata <= r_wr ? 32'h0 : io_bus.m_dout;
                        r_err   <= 1'b0;
                        r_done  <= NREQ'(1) << r_idx;
                        r_state <= S_DONE;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_done  <= NREQ'(1) << r_idx;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_addr  <= '0;
                    r_wr    <= 1'b0;
                    r_dina  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.gnt         = r_gnt;
    assign io_bus.done        = r_done;
    assign io_bus.err         = r_err;
    assign io_bus.rdata       = r_rdata;
    assign io_bus.m_enable    = r_enable;
    assign io_bus.m_addr      = r_addr;
    assign io_bus.m_wr        = r_wr;
    assign io_bus.m_dina      = r_dina;
    assign io_bus.m_slave_sel = r_addr[31:30];

endmodule

// File: doc/ahb_req_arbiter.md
# ahb_req_arbiter

Round-robin arbiter and transaction sequencer that shares the single `ahb_master` instance between NREQ local requesters. It grants one requester at a time and drives the master's `enable`, `addr`, `wr`, `dina` and `slave_sel` inputs. It tracks the master's registered `hready` to detect completion, then returns read data and a one-cycle completion pulse to the granted requester. A timeout counter aborts transactions that never complete.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 16, max WAIT cycles before abort (>=4)
- hclk  in  1  clock, rising edge
- hresetn  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request; held high until its `done`
- req_wr  in  NREQ  per-requester direction (1 = write)
- req_addr  in  NREQ*32  per-requester address; slice i = [32i+31:32i]
- req_wdata  in  NREQ*32  per-requester write data, same slicing
- gnt  out  NREQ  one-hot grant, high from ISSUE through DONE
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  high with `done` when the transaction timed out
- rdata  out  32  read data, valid while `done` is high
- m_enable  out  1  to master `enable`
- m_addr  out  32  to master `addr`
- m_wr  out  1  to master `wr`
- m_dina  out  32  to master `dina`
- m_slave_sel  out  2  to master `slave_sel`; equals `m_addr[31:30]`
- m_hready  in  1  from master `hready`
- m_dout  in  32  from master `dout`

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any `req` is high, select a winner with `rr_pick` using pointer `ptr`.
  - Register the winner's index, addr, wr and wdata. Set its `gnt` bit. Go to ISSUE.
  - Otherwise stay in IDLE.
- **Round-robin rule**
  - Search starts at index `ptr` and wraps modulo NREQ.
  - After each grant, `ptr` becomes winner+1, wrapping NREQ-1 to 0.
- **ISSUE**
  - `m_enable` = 1 for exactly this one cycle.
  - Clear `hcnt` and `tcnt`. Go to WAIT.
- **m_addr / m_wr / m_dina / m_slave_sel**
  - Driven from the registered copy of the winner's request.
  - Stable from ISSUE through DONE; zero in IDLE.
- **WAIT**
  - `tcnt` increments each cycle.
  - `hcnt` increments each cycle that `m_hready` = 1.
  - On the cycle where `m_hready` = 1 and `hcnt` == 1 (second hready-high cycle):
    - read: capture `m_dout` into `rdata`.
    - write: capture 0 into `rdata`.
    - Clear `err`. Go to DONE.
  - Else, if `tcnt` == TIMEOUT-1: set `rdata` = 0 and `err` = 1. Go to DONE.
- **DONE**
  - `done[idx]` = 1 for one cycle; `gnt` stays held.
  - Next state is IDLE; `gnt` clears there.
- A requester whose `req` is still high in IDLE after its `done` is treated as a new request, subject to round-robin.
- A requester dropping `req` mid-transaction does not abort it; the transaction completes and `done` still pulses.
- `req_*` inputs are ignored outside IDLE.
- Reset, at any time including mid-transaction:
  - state = IDLE, `ptr` = 0, counters = 0.
  - All outputs = 0 (`gnt`, `done`, `err`, `rdata`, `m_*`).
  - The master is reset by the same `hresetn`, so no bus cleanup is needed.

## Timing
- All outputs are registered. Cycle 0 is the IDLE cycle in which `req` is sampled.
  - c1: ISSUE; `gnt` and `m_enable` high.
  - c2: master in ADDR phase.
  - c3: master DATA/RESPONSE phase; first `m_hready` high.
  - c4: master back in IDLE; second `m_hready` high; `m_dout` holds the captured hrdata, latched here.
  - c5: DONE, with `done`/`rdata` valid.
  - c6: IDLE.
- Request-to-`done` latency is 5 cycles; back-to-back issue period is 6 cycles.
- `m_enable` is low from c2 onward, so the master does not re-enter ADDR at c4.
- `err` and `rdata` are valid only while `done` is high. `rdata` holds its value otherwise, and is 0 after reset.

## Structure
- Package `ahb_arb_pkg`:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
  - default NREQ and TIMEOUT constants.
  - index width function `clog2(NREQ)`.
- Sub-module `rr_pick`:
  - combinational: inputs `req`, `ptr`; outputs `valid` and `idx`.
  - rotate, priority-encode, un-rotate.
- `ahb_req_arbiter` contains the FSM, the `hcnt`/`tcnt` counters, the request capture registers and the `ptr` register.

## Test plan
- Single read, with `ahb_master` and a model slave returning hrdata=32'hDEAD_BEEF: req[0]=1, addr=32'h4000_0010 -> `m_enable` one cycle at c1, `m_slave_sel`=2'b01, `done[0]` at c5, `rdata`=32'hDEAD_BEEF, `err`=0.
- Write: req[2]=1, wr=1, wdata=32'h1234_5678 -> `m_dina`=32'h1234_5678 stable c1..c5, `done[2]` at c5, `rdata`=0.
- Fairness: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0, one `done` every 6 cycles.
- Pointer wrap: req=4'b1001 after a grant to 3 -> next grant is 0, then 3.
- Timeout: `m_hready` forced 0 -> `done` with `err`=1 and `rdata`=0 exactly TIMEOUT cycles after WAIT entry.
- Reset in WAIT: assert `hresetn` at c3 -> all outputs 0 immediately; after release, req[1] is granted first because `ptr`=0 and req[0]=0.
